// File: rtl/neuron_mac_seq_pkg.sv
// neuron_pkg: shared FSM states and width helpers for the sequential MAC neuron.
package neuron_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_OUT} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  // Sign bit plus growth for N terms; keeps the full range of N extreme weights (and a bias).
  function automatic int acc_width(input int n, input int w);
    return w + clog2(n) + 1;
  endfunction
endpackage

// File: rtl/neuron_mac_seq_if.sv
// neuron_mac_seq_if: input/output handshakes of the MAC neuron; bias_i exists only with NEURON_MAC_BIAS_EN.
interface neuron_mac_seq_if #(parameter int N_INPUTS = 4, parameter int W_WIDTH = 8, parameter int OUT_W = 10);
  logic in_valid_i;
  logic in_ready_o;
  logic [N_INPUTS-1:0] x_i;
  logic [N_INPUTS*W_WIDTH-1:0] w_i;
  logic out_valid_o;
  logic out_ready_i;
  logic [OUT_W-1:0] neuron_o;
  logic sat_o;
  logic [N_INPUTS*W_WIDTH-1:0] weights_o;
`ifdef NEURON_MAC_BIAS_EN
  logic signed [W_WIDTH-1:0] bias_i;
  modport slave (input in_valid_i, x_i, w_i, out_ready_i, bias_i,
                 output in_ready_o, out_valid_o, neuron_o, sat_o, weights_o);
  modport master (output in_valid_i, x_i, w_i, out_ready_i, bias_i,
                  input in_ready_o, out_valid_o, neuron_o, sat_o, weights_o);
`else
  modport slave (input in_valid_i, x_i, w_i, out_ready_i,
                 output in_ready_o, out_valid_o, neuron_o, sat_o, weights_o);
  modport master (output in_valid_i, x_i, w_i, out_ready_i,
                  input in_ready_o, out_valid_o, neuron_o, sat_o, weights_o);
`endif
endinterface

// File: rtl/neuron_relu_sat.sv
// neuron_relu_sat: ReLU with upper saturation from a signed accumulator to an unsigned output.
module neuron_relu_sat #(parameter int ACC_W = 11, parameter int OUT_W = 10) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic [OUT_W-1:0] value_o,
  output logic sat_o
);
  localparam int EW = (ACC_W > OUT_W ? ACC_W : OUT_W) + 1;
  logic signed [EW-1:0] a, lim;
  always_comb begin
    a = EW'(acc_i);
    lim = EW'({1'b0, {OUT_W{1'b1}}});
    sat_o = a > lim;
    value_o = (a <= 0) ? '0 : sat_o ? '1 : a[OUT_W-1:0];
  end
endmodule

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: sequential N-input neuron, one weight term per cycle, then ReLU/saturation.
// Optional NEURON_MAC_BIAS_EN adds a signed bias that seeds the accumulator.
module neuron_mac_seq
  import neuron_pkg::*;
#(parameter int N_INPUTS = 4, parameter int W_WIDTH = 8, parameter int OUT_W = 10) (
  input logic clk_i,
  input logic rst_i,
  input logic en_i,
  neuron_mac_seq_if.slave io
);
  localparam int ACC_W = acc_width(N_INPUTS, W_WIDTH);
  localparam int IW = clog2(N_INPUTS);
  state_t state;
  logic signed [ACC_W-1:0] acc, sum, init;
  logic [IW-1:0] idx;
  logic [N_INPUTS-1:0] x_q;
  logic signed [W_WIDTH-1:0] wk;
  logic [OUT_W-1:0] act;
  logic act_sat;
  // weights_o doubles as the captured weight store
  assign wk = io.weights_o[idx*W_WIDTH +: W_WIDTH];
  assign sum = acc + (x_q[idx] ? ACC_W'(wk) : '0);
`ifdef NEURON_MAC_BIAS_EN
  assign init = ACC_W'(io.bias_i);
`else
  assign init = '0;
`endif
  assign io.in_ready_o = rst_i & en_i & (state == ST_IDLE);
  neuron_relu_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_relu (.acc_i(sum), .value_o(act), .sat_o(act_sat));
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state <= ST_IDLE;
      acc <= '0;
      idx <= '0;
      x_q <= '0;
      io.out_valid_o <= 1'b0;
      io.neuron_o <= '0;
      io.sat_o <= 1'b0;
      io.weights_o <= '0;
    end else if (en_i)
      case (state)
        ST_IDLE: if (io.in_valid_i) begin
          x_q <= io.x_i;
          io.weights_o <= io.w_i;
          acc <= init;
          idx <= '0;
          state <= ST_ACCUM;
        end
        ST_ACCUM: begin
          acc <= sum;
          idx <= idx + 1'b1;
          if (idx == IW'(N_INPUTS - 1)) begin
            io.neuron_o <= act;
            io.sat_o <= act_sat;
            io.out_valid_o <= 1'b1;
            state <= ST_OUT;
          end
        end
        ST_OUT: if (io.out_ready_i) begin
          io.out_valid_o <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
endmodule

// File: tb/tb_neuron_mac_seq.sv
// tb_neuron_mac_seq: directed table plus corner sequences; two DUTs (OUT_W=10 and OUT_W=8) share stimulus.
module tb_neuron_mac_seq;
  logic clk_i = 1'b0, rst_i = 1'b0, en_i = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] x_v = '0;
  logic [31:0] w_v = '0;
  logic [7:0] bias_v = '0;
  int n_cmp = 0, n_bad = 0, cyc = 0, t0 = 0, lat = 0;
  neuron_mac_seq_if #(.N_INPUTS(4), .W_WIDTH(8), .OUT_W(10)) ia ();
  neuron_mac_seq_if #(.N_INPUTS(4), .W_WIDTH(8), .OUT_W(8)) ib ();
  assign ia.in_valid_i = in_valid;
  assign ib.in_valid_i = in_valid;
  assign ia.out_ready_i = out_ready;
  assign ib.out_ready_i = out_ready;
  assign ia.x_i = x_v;
  assign ib.x_i = x_v;
  assign ia.w_i = w_v;
  assign ib.w_i = w_v;
`ifdef NEURON_MAC_BIAS_EN
  assign ia.bias_i = bias_v;
  assign ib.bias_i = bias_v;
`endif
  neuron_mac_seq #(.N_INPUTS(4), .W_WIDTH(8), .OUT_W(10)) u_dut (.clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .io(ia));
  neuron_mac_seq #(.N_INPUTS(4), .W_WIDTH(8), .OUT_W(8)) u_dut8 (.clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .io(ib));
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  typedef struct {
    logic [3:0] x;
    logic [31:0] w;
    logic [9:0] n10;
    logic s10;
    logic [7:0] n8;
    logic s8;
  } vec_t;
  vec_t tbl[10];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic launch(input logic [3:0] x, input logic [31:0] w);
    @(negedge clk_i);
    x_v = x;
    w_v = w;
    in_valid = 1'b1;
    chk("in_ready_idle", {63'd0, ia.in_ready_o}, 64'd1);
    @(negedge clk_i);
    in_valid = 1'b0;
    t0 = cyc;
  endtask
  task automatic await_out();
    for (int i = 0; i < 40 && !ia.out_valid_o; i++) @(negedge clk_i);
    chk("out_valid_timeout", {63'd0, ia.out_valid_o}, 64'd1);
    chk("out_valid_b", {63'd0, ib.out_valid_o}, 64'd1);
    lat = cyc - t0;
  endtask
  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk_i);
    out_ready = 1'b0;
    chk("out_valid_drop", {63'd0, ia.out_valid_o}, 64'd0);
  endtask
  initial begin
    tbl[0] = '{4'b1111, 32'h40404040, 10'd256, 1'b0, 8'd255, 1'b1};
    tbl[1] = '{4'b1111, 32'h807F1020, 10'd47, 1'b0, 8'd47, 1'b0};
    tbl[2] = '{4'b1000, 32'h807F1020, 10'd0, 1'b0, 8'd0, 1'b0};
    tbl[3] = '{4'b0000, 32'h7F7F7F7F, 10'd0, 1'b0, 8'd0, 1'b0};
    tbl[4] = '{4'b1111, 32'h7F7F7F7F, 10'd508, 1'b0, 8'd255, 1'b1};
    tbl[5] = '{4'b0101, 32'h10203040, 10'd96, 1'b0, 8'd96, 1'b0};
    tbl[6] = '{4'b1111, 32'h80808080, 10'd0, 1'b0, 8'd0, 1'b0};
    tbl[7] = '{4'b1111, 32'h7F7F0100, 10'd255, 1'b0, 8'd255, 1'b0};
    tbl[8] = '{4'b1111, 32'h7F7F0200, 10'd256, 1'b0, 8'd255, 1'b1};
    tbl[9] = '{4'b0011, 32'hFFFF0001, 10'd1, 1'b0, 8'd1, 1'b0};
    #12;
    chk("rst_in_ready", {63'd0, ia.in_ready_o}, 64'd0);
    chk("rst_out_valid", {63'd0, ia.out_valid_o}, 64'd0);
    chk("rst_neuron", {54'd0, ia.neuron_o}, 64'd0);
    chk("rst_weights", {32'd0, ia.weights_o}, 64'd0);
    rst_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      launch(tbl[i].x, tbl[i].w);
      await_out();
      chk($sformatf("lat[%0d]", i), 64'(lat), 64'd4);
      chk($sformatf("n10[%0d]", i), {54'd0, ia.neuron_o}, {54'd0, tbl[i].n10});
      chk($sformatf("s10[%0d]", i), {63'd0, ia.sat_o}, {63'd0, tbl[i].s10});
      chk($sformatf("n8[%0d]", i), {56'd0, ib.neuron_o}, {56'd0, tbl[i].n8});
      chk($sformatf("s8[%0d]", i), {63'd0, ib.sat_o}, {63'd0, tbl[i].s8});
      chk($sformatf("weights[%0d]", i), {32'd0, ia.weights_o}, {32'd0, tbl[i].w});
      drain();
    end
    // backpressure with new data offered during OUT
    launch(4'b1111, 32'h40404040);
    await_out();
    x_v = 4'b1111;
    w_v = 32'h7F7F7F7F;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("bp_valid", {63'd0, ia.out_valid_o}, 64'd1);
      chk("bp_neuron", {54'd0, ia.neuron_o}, 64'd256);
      chk("bp_in_ready", {63'd0, ia.in_ready_o}, 64'd0);
      chk("bp_weights", {32'd0, ia.weights_o}, 64'h40404040);
    end
    out_ready = 1'b1;
    @(negedge clk_i);
    out_ready = 1'b0;
    chk("bp_release_valid", {63'd0, ia.out_valid_o}, 64'd0);
    chk("bp_release_ready", {63'd0, ia.in_ready_o}, 64'd1);
    chk("bp_no_capture", {32'd0, ia.weights_o}, 64'h40404040);
    @(negedge clk_i);
    in_valid = 1'b0;
    t0 = cyc;
    chk("bp_next_capture", {32'd0, ia.weights_o}, 64'h7F7F7F7F);
    await_out();
    chk("bp_next_lat", 64'(lat), 64'd4);
    chk("bp_next_neuron", {54'd0, ia.neuron_o}, 64'd508);
    drain();
    // enable gap of 3 cycles mid-ACCUM
    launch(4'b1111, 32'h807F1020);
    @(negedge clk_i);
    en_i = 1'b0;
    x_v = 4'b0000;
    w_v = 32'h7F7F7F7F;
    repeat (3) @(negedge clk_i);
    chk("en_off_ready", {63'd0, ia.in_ready_o}, 64'd0);
    en_i = 1'b1;
    await_out();
    chk("en_gap_lat", 64'(lat), 64'd7);
    chk("en_gap_neuron", {54'd0, ia.neuron_o}, 64'd47);
    drain();
    en_i = 1'b0;
    #1;
    chk("en_off_idle_ready", {63'd0, ia.in_ready_o}, 64'd0);
    en_i = 1'b1;
    // asynchronous reset mid-ACCUM
    launch(4'b1111, 32'h40404040);
    @(negedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    chk("arst_valid", {63'd0, ia.out_valid_o}, 64'd0);
    chk("arst_neuron", {54'd0, ia.neuron_o}, 64'd0);
    chk("arst_weights", {32'd0, ia.weights_o}, 64'd0);
    chk("arst_ready", {63'd0, ia.in_ready_o}, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (6) @(negedge clk_i);
    chk("arst_no_output", {63'd0, ia.out_valid_o}, 64'd0);
    chk("arst_release_ready", {63'd0, ia.in_ready_o}, 64'd1);
`ifdef NEURON_MAC_BIAS_EN
    bias_v = 8'hF0;
    launch(4'b0011, 32'h08080808);
    await_out();
    chk("bias_neg", {54'd0, ia.neuron_o}, 64'd0);
    chk("bias_neg_lat", 64'(lat), 64'd4);
    drain();
    bias_v = 8'h10;
    launch(4'b0011, 32'h08080808);
    await_out();
    chk("bias_pos", {54'd0, ia.neuron_o}, 64'd32);
    drain();
    bias_v = 8'h00;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/neuron_mac_seq.md
Name: neuron_mac_seq

Overview:
- Parametrised, sequential successor to the 4-input hidden neuron.
- Accepts an N-bit binary input vector and N signed fixed-point weights through a valid/ready handshake.
- Accumulates one weight term per cycle on a single shared adder, then applies ReLU with saturation.
- Registered result goes out on a valid/ready output port; it feeds the output layer or the next hidden layer.

Parameters:
- N_INPUTS, 4: number of binary inputs and weights; must be >= 2.
- W_WIDTH, 8: weight width, signed two's complement, Q1.(W_WIDTH-1).
- OUT_W, 10: output width, unsigned, same fractional bits as the weights (W_WIDTH-1).
- ACC_W, W_WIDTH+$clog2(N_INPUTS)+1: signed accumulator width; derived, do not override.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- en_i  in  1  global enable; when 0, FSM, accumulator, index and all output registers hold.
- in_valid_i  in  1  input vector and weights valid.
- in_ready_o  out  1  high only in IDLE with en_i=1.
- x_i  in  N_INPUTS  binary inputs; bit k selects weight k.
- w_i  in  N_INPUTS*W_WIDTH  packed signed weights; weight k = w_i[k*W_WIDTH +: W_WIDTH].
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- neuron_o  out  OUT_W  activated result.
- sat_o  out  1  result was clipped at the upper bound; qualified by out_valid_o.
- weights_o  out  N_INPUTS*W_WIDTH  registered copy of the weights captured at acceptance.

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE; accumulator, index, out_valid_o, neuron_o, sat_o and weights_o = 0. in_ready_o=0 while reset is asserted.
- Reset mid-operation aborts the computation with no output.
- FSM: IDLE -> ACCUM -> OUT -> IDLE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i & in_ready_o: capture x_i and w_i, copy w_i to weights_o, clear the accumulator, set idx=0, go to ACCUM.
- ACCUM (exactly N_INPUTS enabled cycles, no zero-skipping):
  - acc += x[idx] ? sign_extend(w[idx]) : 0; then idx++.
  - After the idx=N_INPUTS-1 term, register the activation of the final sum into neuron_o and sat_o, set out_valid_o=1, go to OUT.
- Latency: handshake at edge k gives out_valid_o=1 after edge k+N_INPUTS (all en_i=1). Each en_i=0 cycle adds one cycle.
- Activation:
  - sum <= 0 -> neuron_o=0, sat_o=0.
  - sum > 2^OUT_W-1 -> neuron_o=all ones, sat_o=1.
  - Otherwise neuron_o=sum[OUT_W-1:0], sat_o=0.
- OUT:
  - neuron_o and sat_o are held stable while out_valid_o=1 & out_ready_i=0.
  - On out_ready_i=1 (with en_i=1): out_valid_o=0, go to IDLE.
  - No bypass: a new input is accepted at the earliest on the cycle after the output handshake.
- Input changes during ACCUM or OUT have no effect, because the inputs were captured at acceptance.
- Accumulator cannot overflow: ACC_W covers N_INPUTS * (-2^(W_WIDTH-1)) through N_INPUTS * (2^(W_WIDTH-1)-1).

Optional Feature:
- Macro: NEURON_MAC_BIAS_EN.
- When defined:
  - Extra input port bias_i, W_WIDTH bits, signed; captured at acceptance.
  - The accumulator initialises to sign_extend(bias_i) instead of 0.
  - Latency is unchanged.
- When undefined: the port is absent and the accumulator initialises to 0.

Decomposition:
- Package neuron_pkg holds:
  - the state enum (ST_IDLE, ST_ACCUM, ST_OUT);
  - a clog2 helper;
  - the function for the derived ACC_W width.
- Sub-module neuron_relu_sat: purely combinational; ACC_W-bit signed in, OUT_W-bit value and sat flag out. Reusable by the output-layer neuron.

Test Plan:
- N=4, W=8, OUT_W=10; w=all 0x40, x=4'b1111 -> neuron_o=256, sat_o=0, out_valid_o exactly 4 edges after the handshake; weights_o=0x40404040.
- w={0x80,0x7F,0x10,0x20} (w3..w0), x=4'b1111 -> sum -128+127+16+32=47 -> neuron_o=47. Same weights with x=4'b1000 -> neuron_o=0 (ReLU).
- OUT_W=8 with w=all 0x7F, x=4'b1111 -> sum 508 -> neuron_o=255, sat_o=1.
- Hold out_ready_i=0 for 5 cycles while in_valid_i=1 with new data -> output stable, in_ready_o=0, no new capture. After out_ready_i=1 -> IDLE, next vector accepted the following cycle.
- Deassert en_i for 3 cycles mid-ACCUM -> result identical, latency +3. Assert rst_i=0 mid-ACCUM -> all outputs 0 immediately and asynchronously; after release, in_ready_o=1.
- With NEURON_MAC_BIAS_EN defined, bias_i=0xF0 (-16), w=all 0x08, x=4'b0011 -> sum 0 -> neuron_o=0. With bias_i=0x10 -> neuron_o=32.
